emif_cal_bus_responder: RTL

- Simulation-side responder (Avalon-MM slave) for the EMIF calibration bus driven by the hard-Nios io_aux sequencer.
- Provides a scratch register RAM and a status register.
- Provides a debug-character port that unpacks sequencer print words into a byte stream with end-of-string marking.
- Sits in the dcp_emif_model alongside the arch wrapper. It terminates cal_bus_* in place of the hard sequencer peripherals, so prints and register traffic are checkable without string handling in the wrapper.

---
 rtl/emif_cal_bus_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/emif_cal_bus_responder.sv
// Simulation-side Avalon-MM responder for the EMIF calibration bus.
// It provides a scratch RAM, a status register and a debug-character unpacker that feeds a FWFT FIFO.
module emif_cal_bus_responder #(
    parameter int          REG_WORDS     = 256,
    parameter int          READ_LATENCY  = 1,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [19:0] DBG_CHAR_ADDR = 20'h1_0000,
    parameter logic [19:0] STATUS_ADDR   = 20'h1_0001
) (
    input  logic        cal_bus_clk,
    input  logic        global_reset_n_int,
    input  logic        cal_bus_avl_read,
    input  logic        cal_bus_avl_write,
    input  logic [19:0] cal_bus_avl_address,
    input  logic [31:0] cal_bus_avl_write_data,
    output logic [31:0] cal_bus_avl_read_data,
    output logic        dbg_char_valid,
    output logic [7:0]  dbg_char,
    output logic        dbg_char_last,
    input  logic        dbg_char_ready,
    output logic        dbg_overflow
);
    localparam int AW = (REG_WORDS > 1) ? $clog2(REG_WORDS) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    typedef enum logic [0:0] {ST_IDLE, ST_UNPACK} state_t;

    logic [31:0]   ram_r  [0:REG_WORDS-1];
    logic [31:0]   pipe_r [0:READ_LATENCY-1];
    logic [8:0]    ent_r  [0:FIFO_DEPTH-1];
    logic [8:0]    ent_nx_s [0:FIFO_DEPTH-1];
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic          valid_r;
    state_t        state_r, state_nx_s;
    logic [31:0]   work_r, work_nx_s, pend_r, pend_nx_s;
    logic [1:0]    idx_r, idx_nx_s;
    logic          pend_v_r, pend_v_nx_s, ovf_r, ovf_nx_s;

    logic          ram_hit_s, port_wr_s, status_clr_s;
    logic [AW-1:0] ram_idx_s;
    logic [31:0]   status_s, rd_sample_s;
    logic          pop_s, full_s, can_push_s, push_s;
    logic [8:0]    push_data_s;
    logic [FW-1:0] wpos_s;
    logic [7:0]    cur_byte_s;
    logic          word_done_s, wr_taken_s, store_s, ovf_set_s;

    assign ram_hit_s    = cal_bus_avl_address < 20'(REG_WORDS);
    assign ram_idx_s    = cal_bus_avl_address[AW-1:0];
    assign port_wr_s    = cal_bus_avl_write && (cal_bus_avl_address == DBG_CHAR_ADDR);
    assign status_clr_s = cal_bus_avl_write && (cal_bus_avl_address == STATUS_ADDR)
                          && cal_bus_avl_write_data[16];
    assign status_s     = {13'd0, (state_r == ST_UNPACK), (cnt_r == CW'(0)), ovf_r, 16'(cnt_r)};

    // Scratch RAM: cleared by reset, written whenever a write hits the RAM range
    always_ff @(posedge cal_bus_clk or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            for (int i = 0; i < REG_WORDS; i++) ram_r[i] <= 32'd0;
        end else if (cal_bus_avl_write && ram_hit_s) begin
            ram_r[ram_idx_s] <= cal_bus_avl_write_data;
        end
    end

    // Read data sampled at the request edge; a read colliding with a write returns 0
    always_comb begin
        rd_sample_s = 32'd0;
        if (cal_bus_avl_read && !cal_bus_avl_write) begin
            if (ram_hit_s)                                 rd_sample_s = ram_r[ram_idx_s];
            else if (cal_bus_avl_address == STATUS_ADDR)   rd_sample_s = status_s;
            else                                           rd_sample_s = 32'd0;
        end else begin
            rd_sample_s = 32'd0;
        end
    end

    // Fixed-latency return pipeline; idle slots carry zero
    always_ff @(posedge cal_bus_clk or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe_r[i] <= 32'd0;
        end else begin
            pipe_r[0] <= rd_sample_s;
            for (int i = 1; i < READ_LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign cal_bus_avl_read_data = pipe_r[READ_LATENCY-1];

    assign pop_s      = valid_r && dbg_char_ready;
    assign full_s     = (cnt_r == CW'(FIFO_DEPTH));
    assign can_push_s = !full_s || pop_s;

    // Byte selector for the word being unpacked (little-endian character order)
    always_comb begin
        case (idx_r)
            2'd0:    cur_byte_s = work_r[7:0];
            2'd1:    cur_byte_s = work_r[15:8];
            2'd2:    cur_byte_s = work_r[23:16];
            2'd3:    cur_byte_s = work_r[31:24];
            default: cur_byte_s = 8'd0;
        endcase
    end

    // Unpacker next state; a word finishing with no pending entry may take a same-cycle port write directly
    always_comb begin
        state_nx_s  = state_r;
        work_nx_s   = work_r;
        idx_nx_s    = idx_r;
        push_s      = 1'b0;
        push_data_s = 9'd0;
        word_done_s = 1'b0;
        wr_taken_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (port_wr_s) begin
                    work_nx_s  = cal_bus_avl_write_data;
                    idx_nx_s   = 2'd0;
                    state_nx_s = ST_UNPACK;
                    wr_taken_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_UNPACK: begin
                if (can_push_s) begin
                    push_s = 1'b1;
                    if (cur_byte_s == 8'd0) begin
                        push_data_s = {1'b1, 8'd0};
                        word_done_s = 1'b1;
                    end else begin
                        push_data_s = {1'b0, cur_byte_s};
                        if (idx_r == 2'd3) word_done_s = 1'b1;
                        else               idx_nx_s    = idx_r + 2'd1;
                    end
                end else begin
                    push_s = 1'b0;
                end
                if (word_done_s) begin
                    if (pend_v_r) begin
                        work_nx_s = pend_r;
                        idx_nx_s  = 2'd0;
                    end else if (port_wr_s) begin
                        work_nx_s  = cal_bus_avl_write_data;
                        idx_nx_s   = 2'd0;
                        wr_taken_s = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_UNPACK;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    assign store_s     = port_wr_s && !wr_taken_s && (!pend_v_r || word_done_s);
    assign ovf_set_s   = port_wr_s && !wr_taken_s && !store_s;
    assign pend_nx_s   = store_s ? cal_bus_avl_write_data : pend_r;
    assign pend_v_nx_s = store_s ? 1'b1 : ((word_done_s && pend_v_r) ? 1'b0 : pend_v_r);
    assign ovf_nx_s    = ovf_set_s ? 1'b1 : (status_clr_s ? 1'b0 : ovf_r);

    // Unpacker state, working word, pending slot and sticky overflow
    always_ff @(posedge cal_bus_clk or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            state_r  <= ST_IDLE;
            work_r   <= 32'd0;
            idx_r    <= 2'd0;
            pend_r   <= 32'd0;
            pend_v_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            work_r   <= work_nx_s;
            idx_r    <= idx_nx_s;
            pend_r   <= pend_nx_s;
            pend_v_r <= pend_v_nx_s;
            ovf_r    <= ovf_nx_s;
        end
    end

    assign wpos_s   = FW'(cnt_r - CW'(pop_s));
    assign cnt_nx_s = cnt_r + CW'(push_s) - CW'(pop_s);

    // Shift-register FIFO: entry 0 is the head, so head outputs come straight from flops
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) ent_nx_s[i] = ent_r[i];
        if (pop_s) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) ent_nx_s[i] = ent_r[i+1];
            ent_nx_s[FIFO_DEPTH-1] = 9'd0;
        end else begin
            ent_nx_s[FIFO_DEPTH-1] = ent_r[FIFO_DEPTH-1];
        end
        if (push_s) ent_nx_s[wpos_s] = push_data_s;
        else        ent_nx_s[0]      = ent_nx_s[0];
    end

    // FIFO storage, occupancy and head-valid flag
    always_ff @(posedge cal_bus_clk or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            for (int i = 0; i < FIFO_DEPTH; i++) ent_r[i] <= 9'd0;
            cnt_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) ent_r[i] <= ent_nx_s[i];
            cnt_r   <= cnt_nx_s;
            valid_r <= (cnt_nx_s != CW'(0));
        end
    end

    assign dbg_char_valid = valid_r;
    assign dbg_char       = ent_r[0][7:0];
    assign dbg_char_last  = ent_r[0][8];
    assign dbg_overflow   = ovf_r;

endmodule
